pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
- REQ-001: Parameter DRAIN_CYCLES, default 4, is the number of cycles needed to empty the ID, EX, MEM and WB stages during halt.
- REQ-002: Parameter MEM_TIMEOUT, default 255, is the maximum number of consecutive mem_busy cycles before mem_timeout.
- REQ-003: clk  in  1  single clock; all logic rising-edge.
- REQ-004: reset  in  1  synchronous, active-high.
- REQ-005: id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- REQ-006: id_uses_rt  in  1  ID instruction reads rt.
- REQ-007: ex_MemRead  in  1;  ex_rt  in  5  load and destination in EX.
- REQ-008: ex_branch_taken, ex_jump  in  1 each  redirect resolved in EX.
- REQ-009: mem_busy  in  1  data memory not ready.
- REQ-010: halt_req  in  1  level request to drain and halt.
- REQ-011: PCWrite  out  1  PC update enable.
- REQ-012: IFID_stall, IFID_flush  out  1 each  IF/ID register controls.
- REQ-013: IDEX_stall, IDEX_flush  out  1 each  ID/EX register controls.
- REQ-014: EXMEM_stall  out  1  EX/MEM hold.
- REQ-015: halted  out  1  pipeline empty and frozen.
- REQ-016: mem_timeout  out  1  sticky error flag.

Function
- REQ-017: The FSM states SHALL be RUN, MEM_WAIT, DRAIN and HALTED.
- REQ-018: All control outputs SHALL be combinational from state and inputs; state, counters and flags SHALL be registered.
- REQ-019: Freeze SHALL mean PCWrite=0, IFID_stall=1, IDEX_stall=1, EXMEM_stall=1 and both flushes 0.
- REQ-020: Priority in RUN SHALL be mem_busy > redirect > load-use > halt_req.
- REQ-021: In RUN with mem_busy=1: freeze, next state MEM_WAIT, wait counter loaded with 1.
- REQ-022: In MEM_WAIT: freeze while mem_busy=1 and increment the saturating wait counter; on the first cycle with mem_busy=0, apply the RUN rules that same cycle and return to RUN.
- REQ-023: mem_timeout SHALL set when the wait counter reaches MEM_TIMEOUT and clear only on reset.
- REQ-024: Redirect (ex_branch_taken|ex_jump) SHALL give PCWrite=1, IFID_flush=1, IDEX_flush=1, with stalls 0, for exactly that cycle.
- REQ-025: Load-use hazard is ex_MemRead & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- REQ-026: A load-use hazard SHALL give PCWrite=0, IFID_stall=1, IDEX_flush=1, for one bubble per detection.
- REQ-027: halt_req in RUN with no higher-priority event SHALL enter DRAIN and load the drain counter with DRAIN_CYCLES.
- REQ-028: In DRAIN: PCWrite=0 and IFID_flush=1 each cycle; the counter decrements only when mem_busy=0 (freeze while busy); at zero the FSM goes to HALTED.
- REQ-029: A redirect during DRAIN SHALL be discarded; only the flushes apply.
- REQ-030: In HALTED: halted=1, PCWrite=0, IFID_stall=1, IDEX_flush=1; halt_req=0 SHALL return the FSM to RUN the next cycle.
- REQ-031: halt_req deasserting during DRAIN SHALL NOT abort the drain.

Reset
- REQ-032: While reset=1 the FSM SHALL be in RUN with counters 0, mem_timeout=0 and halted=0.
- REQ-033: While reset=1 the outputs SHALL be PCWrite=0, IFID_flush=1, IDEX_flush=1 and all stalls 0.
- REQ-034: Reset mid-DRAIN or mid-MEM_WAIT SHALL abandon the operation.

Configuration
- REQ-035: Macro PIPELINE_CTRL_STATS_EN SHALL add outputs stall_cnt, flush_cnt and halt_cnt (32-bit each, wrapping).
- REQ-036: With the macro, the counters SHALL count cycles with any stall, cycles with any flush, and cycles in HALTED; all three reset to 0.
- REQ-037: Without the macro, these ports and registers SHALL be absent.

Structure
- REQ-038: A shared package pipe_pkg SHALL hold the state enum, the freeze/flush control-bundle typedef and the default parameter constants.
- REQ-039: Sub-module hazard_detect SHALL be the combinational load-use comparator; all other logic stays in pipeline_ctrl.

Verification
- REQ-040: ex_MemRead=1, ex_rt=8, id_rs=8 -> one cycle of PCWrite=0, IFID_stall=1, IDEX_flush=1; ex_rt=0 -> no stall.
- REQ-041: ex_branch_taken=1 together with a load-use hazard -> redirect wins: IFID_flush=IDEX_flush=1 and PCWrite=1.
- REQ-042: mem_busy high for 5 cycles with a branch in EX -> freeze for 5 cycles, then flush on cycle 6.
- REQ-043: mem_busy held for 300 cycles -> mem_timeout=1 at cycle 255; it stays set after mem_busy drops.
- REQ-044: halt_req pulsed for 1 cycle -> 4 cycles of IFID_flush, then halted=1 until halt_req is low (already low, so RUN the next cycle); halt_req held -> halted stays 1.
- REQ-045: Reset asserted mid-DRAIN -> RUN the next cycle with halted=0 and counters 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/halt controller:
// FSM state encoding, the per-cycle control bundle and its canned patterns.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic idex_flush;
        logic exmem_stall;
    } ctrl_t;

    localparam int DRAIN_CYCLES_DEF = 4;
    localparam int MEM_TIMEOUT_DEF  = 255;

    // Bit order: pc_write, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall
    localparam ctrl_t CTRL_NORMAL     = ctrl_t'(6'b100000);
    localparam ctrl_t CTRL_FREEZE     = ctrl_t'(6'b010101);
    localparam ctrl_t CTRL_REDIRECT   = ctrl_t'(6'b101010);
    localparam ctrl_t CTRL_BUBBLE     = ctrl_t'(6'b010010);
    localparam ctrl_t CTRL_RESET      = ctrl_t'(6'b001010);
    localparam ctrl_t CTRL_DRAIN      = ctrl_t'(6'b001000);
    localparam ctrl_t CTRL_DRAIN_BUSY = ctrl_t'(6'b001101);
    localparam ctrl_t CTRL_HALTED     = ctrl_t'(6'b010010);

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: a load in EX whose destination is read
// by the instruction currently in ID.
module hazard_detect (
    input  logic       ex_MemRead,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       hazard
);
    always_comb begin
        hazard = ex_MemRead && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/halt controller with memory-wait timeout detection.
// Define PIPELINE_CTRL_STATS_EN to add the stall/flush/halt cycle counters.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_MemRead,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        ex_jump,
    input  logic        mem_busy,
    input  logic        halt_req,
    output logic        PCWrite,
    output logic        IFID_stall,
    output logic        IFID_flush,
    output logic        IDEX_stall,
    output logic        IDEX_flush,
    output logic        EXMEM_stall,
    output logic        halted,
`ifdef PIPELINE_CTRL_STATS_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] halt_cnt,
`endif
    output logic        mem_timeout
);
    localparam int WAIT_W  = (MEM_TIMEOUT  < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic [DRAIN_W-1:0]  drain_cnt, drain_nxt;
    logic                timeout_flag;
    logic                load_use;
    logic                redirect;
    ctrl_t               ctl;

    hazard_detect u_hazard (
        .ex_MemRead (ex_MemRead),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .hazard     (load_use)
    );

    assign redirect = ex_branch_taken | ex_jump;

    always_comb begin
        ctl       = CTRL_NORMAL;
        state_nxt = state;
        wait_nxt  = '0;
        drain_nxt = drain_cnt;
        case (state)
            // MEM_WAIT falls back onto the RUN rules in the cycle memory frees up
            RUN, MEM_WAIT: begin
                if (mem_busy) begin
                    ctl       = CTRL_FREEZE;
                    state_nxt = MEM_WAIT;
                    if (state == RUN)
                        wait_nxt = WAIT_W'(1);
                    else if (wait_cnt >= WAIT_MAX)
                        wait_nxt = WAIT_MAX;
                    else
                        wait_nxt = wait_cnt + WAIT_W'(1);
                end else begin
                    state_nxt = RUN;
                    if (redirect) begin
                        ctl = CTRL_REDIRECT;
                    end else if (load_use) begin
                        ctl = CTRL_BUBBLE;
                    end else if (halt_req) begin
                        state_nxt = DRAIN;
                        drain_nxt = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (mem_busy) begin
                    ctl = CTRL_DRAIN_BUSY;
                end else begin
                    ctl = CTRL_DRAIN;
                    if (drain_cnt <= DRAIN_W'(1)) begin
                        state_nxt = HALTED;
                        drain_nxt = '0;
                    end else begin
                        drain_nxt = drain_cnt - DRAIN_W'(1);
                    end
                end
            end
            HALTED: begin
                ctl = CTRL_HALTED;
                if (!halt_req)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
        if (reset)
            ctl = CTRL_RESET;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= '0;
            drain_cnt    <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_nxt;
            drain_cnt    <= drain_nxt;
            timeout_flag <= timeout_flag || ((state_nxt == MEM_WAIT) && (wait_nxt == WAIT_MAX));
        end
    end

    assign PCWrite     = ctl.pc_write;
    assign IFID_stall  = ctl.ifid_stall;
    assign IFID_flush  = ctl.ifid_flush;
    assign IDEX_stall  = ctl.idex_stall;
    assign IDEX_flush  = ctl.idex_flush;
    assign EXMEM_stall = ctl.exmem_stall;
    assign halted      = (state == HALTED) && !reset;
    assign mem_timeout = timeout_flag && !reset;

`ifdef PIPELINE_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            halt_cnt  <= '0;
        end else begin
            if (ctl.ifid_stall || ctl.idex_stall || ctl.exmem_stall)
                stall_cnt <= stall_cnt + 32'd1;
            if (ctl.ifid_flush || ctl.idex_flush)
                flush_cnt <= flush_cnt + 32'd1;
            if (state == HALTED)
                halt_cnt <= halt_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed per-cycle vectors push the
// expected control pattern; a monitor pops and compares on each falling edge.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rt = 1'b0, ex_MemRead = 1'b0;
    logic       ex_branch_taken = 1'b0, ex_jump = 1'b0;
    logic       mem_busy = 1'b0, halt_req = 1'b0;
    logic       PCWrite, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_stall;
    logic       halted, mem_timeout;
`ifdef PIPELINE_CTRL_STATS_EN
    logic [31:0] stall_cnt, flush_cnt, halt_cnt;
`endif

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_MemRead      (ex_MemRead),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .ex_jump         (ex_jump),
        .mem_busy        (mem_busy),
        .halt_req        (halt_req),
        .PCWrite         (PCWrite),
        .IFID_stall      (IFID_stall),
        .IFID_flush      (IFID_flush),
        .IDEX_stall      (IDEX_stall),
        .IDEX_flush      (IDEX_flush),
        .EXMEM_stall     (EXMEM_stall),
        .halted          (halted),
`ifdef PIPELINE_CTRL_STATS_EN
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .halt_cnt        (halt_cnt),
`endif
        .mem_timeout     (mem_timeout)
    );

    // {PCWrite, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_stall, halted, mem_timeout}
    localparam logic [7:0] NRM = 8'b1000_0000;
    localparam logic [7:0] FRZ = 8'b0101_0100;
    localparam logic [7:0] RDR = 8'b1010_1000;
    localparam logic [7:0] BUB = 8'b0100_1000;
    localparam logic [7:0] RST = 8'b0010_1000;
    localparam logic [7:0] DRN = 8'b0010_0000;
    localparam logic [7:0] DRB = 8'b0011_0100;
    localparam logic [7:0] HLT = 8'b0100_1010;
    localparam logic [7:0] TO  = 8'b0000_0001;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } sb_t;

    sb_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;

    initial begin : monitor
        sb_t        e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {PCWrite, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush,
                       EXMEM_stall, halted, mem_timeout};
                vectors++;
                if (act !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: got %b expected %b (PC,IFs,IFf,IDs,IDf,EXs,hlt,to)",
                             e.name, act, e.exp);
                end
            end
        end
    end

    task automatic step(input logic rst_v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic mr, input logic [4:0] ert,
                        input logic br, input logic jp, input logic busy, input logic hr,
                        input logic [7:0] e, input string nm);
        sb_t s;
        @(posedge clk);
        #1;
        reset = rst_v; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_MemRead = mr; ex_rt = ert; ex_branch_taken = br; ex_jump = jp;
        mem_busy = busy; halt_req = hr;
        s.exp  = e;
        s.name = nm;
        sb.push_back(s);
    endtask

    task automatic idle(input logic [7:0] e, input string nm);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e, nm);
    endtask

    task automatic halt_pulse(input string nm);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NRM, {nm, "_enter"});
        for (int i = 0; i < 4; i++)
            idle(DRN, {nm, "_drain"});
        idle(HLT, {nm, "_halted"});
        idle(NRM, {nm, "_resume"});
    endtask

    initial begin : stimulus
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, "reset0");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, "reset1");
        idle(NRM, "run_idle");

        // load-use
        step(0, 8, 0, 0, 1, 8, 0, 0, 0, 0, BUB, "loaduse_rs");
        idle(NRM, "loaduse_one_bubble");
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, NRM, "loaduse_r0");
        step(0, 3, 9, 1, 1, 9, 0, 0, 0, 0, BUB, "loaduse_rt");
        step(0, 3, 9, 0, 1, 9, 0, 0, 0, 0, NRM, "loaduse_rt_unused");
        step(0, 8, 0, 0, 0, 8, 0, 0, 0, 0, NRM, "no_load");

        // redirect priority
        step(0, 8, 0, 0, 1, 8, 1, 0, 0, 0, RDR, "branch_over_loaduse");
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, RDR, "jump");
        step(0, 8, 0, 0, 1, 8, 0, 0, 0, 1, BUB, "loaduse_over_halt");
        idle(NRM, "no_drain_after_bubble");

        // memory wait with a pending branch
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, FRZ, "busy_freeze");
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, RDR, "busy_release_flush");
        idle(NRM, "after_busy");

        halt_pulse("halt_pulse");

        // held halt, busy and redirect inside drain
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NRM, "hold_enter");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DRN, "hold_drain4");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, DRB, "hold_drain_busy");
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, DRN, "drain_redirect_dropped");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DRN, "hold_drain2");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DRN, "drain_not_aborted");
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, HLT, "hold_halted");
        idle(HLT, "halted_release");
        idle(NRM, "halted_to_run");

        // reset in the middle of a drain and of a memory wait
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NRM, "rstdrain_enter");
        idle(DRN, "rstdrain_d1");
        idle(DRN, "rstdrain_d2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, "rstdrain_reset");
        idle(NRM, "rstdrain_run");
        halt_pulse("drain_reload");
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, "rstwait_busy");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, RST, "rstwait_reset");
        idle(NRM, "rstwait_run");

        // timeout: counter reaches 255 on the 255th busy edge
        for (int i = 1; i <= 300; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, (i >= 256) ? (FRZ | TO) : FRZ, "timeout_busy");
        idle(NRM | TO, "timeout_sticky");
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, RDR | TO, "timeout_sticky_branch");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, "timeout_reset");
        idle(NRM, "timeout_cleared");

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_scoreboard: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
